// File: rtl/apple_video_fetch.sv
// Apple II scanline fetcher: derives the scanner base address for a line from
// the soft-switch state, reads 20 interleaved words from shadow memory, and
// delivers them through a small first-word-fall-through FIFO.
module apple_video_fetch #(
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk_logic,
  input  logic        system_reset_n,
  input  logic        line_start_i,
  input  logic [8:0]  line_i,
  input  logic        text_mode_i,
  input  logic        mixed_mode_i,
  input  logic        page2_i,
  input  logic        hires_mode_i,
  input  logic        store80_i,
  output logic [15:0] video_address_o,
  output logic        video_rd_o,
  input  logic [31:0] video_data_i,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic        word_last_o,
  output logic        line_done_o,
  output logic        busy_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int LW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [4:0]    K_LAST   = 5'd19;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [15:0]     addr_q, addr_d;
  logic [4:0]      k_q, k_d;
  logic [LW-1:0]   lat_q, lat_d;
  logic            empty_done_q, empty_done_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [32:0]     mem_q [FIFO_DEPTH];

  logic            pg;
  logic            use_text;
  logic [4:0]      row;
  logic [15:0]     text_base;
  logic [15:0]     hires_base;
  logic [15:0]     line_base;
  logic            line_ok;
  logic [32:0]     head;
  logic            fifo_valid;
  logic            issue;
  logic            push;
  logic            pop;

  // Base address of the requested line; text rows are interleaved in thirds
  // of 40 bytes, hires lines additionally interleave the low 3 line bits.
  assign pg         = page2_i & ~store80_i;
  assign use_text   = text_mode_i | (mixed_mode_i & (line_i >= 9'd160)) | ~hires_mode_i;
  assign row        = line_i[7:3];
  assign text_base  = 16'h0400 + (pg ? 16'h0400 : 16'h0000)
                    + {6'b0, row[2:0], 7'b0}
                    + ({14'b0, row[4:3]} * 16'd40);
  assign hires_base = 16'h2000 + (pg ? 16'h2000 : 16'h0000)
                    + {3'b0, line_i[2:0], 10'b0}
                    + {6'b0, line_i[5:3], 7'b0}
                    + ({14'b0, line_i[7:6]} * 16'd40);
  assign line_base  = use_text ? text_base : hires_base;
  assign line_ok    = line_i < 9'd192;

  assign head       = mem_q[rd_ptr_q];
  assign fifo_valid = (count_q != '0);
  assign pop        = fifo_valid & word_ready_i;

  // Only one read is ever in flight and none is outstanding in ISSUE, so the
  // occupancy check alone guarantees the capture has a free slot. A new
  // line_start suppresses issue/capture because that cycle flushes everything.
  assign issue      = (state_q == ISSUE) && (count_q < DEPTH_C) && !line_start_i;
  assign push       = (state_q == WAIT) && (lat_q == LAT_LAST) && !line_start_i;

  assign video_address_o = addr_q;
  assign video_rd_o      = issue;
  assign word_valid_o    = fifo_valid;
  assign word_o          = fifo_valid ? head[31:0] : 32'h0;
  assign word_last_o     = fifo_valid & head[32];
  assign busy_o          = (state_q != IDLE) | fifo_valid;
  assign line_done_o     = empty_done_q
                         | ((state_q == DRAIN) & pop & head[32] & ~line_start_i);

  // Next-state and fetch-sequencing decisions; a line_start always restarts.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    k_d          = k_q;
    lat_d        = lat_q;
    empty_done_d = 1'b0;
    if (line_start_i) begin
      if (line_ok) begin
        state_d = ISSUE;
        addr_d  = line_base;
        k_d     = 5'd0;
        lat_d   = '0;
      end else begin
        state_d      = IDLE;
        empty_done_d = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: ;
        ISSUE: begin
          if (issue) begin
            state_d = WAIT;
            lat_d   = '0;
          end
        end
        WAIT: begin
          if (lat_q == LAT_LAST) begin
            if (k_q == K_LAST) begin
              state_d = DRAIN;
            end else begin
              state_d = ISSUE;
              k_d     = k_q + 5'd1;
              addr_d  = addr_q + 16'd2;
            end
          end else begin
            lat_d = lat_q + LW'(1);
          end
        end
        DRAIN: begin
          if (pop && head[32]) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FIFO pointer and occupancy bookkeeping; line_start empties the FIFO.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (line_start_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // Control and pointer registers with asynchronous reset.
  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q      <= IDLE;
      addr_q       <= 16'h0000;
      k_q          <= 5'd0;
      lat_q        <= '0;
      empty_done_q <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      k_q          <= k_d;
      lat_q        <= lat_d;
      empty_done_q <= empty_done_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
    end
  end

  // FIFO storage: data word plus a last-of-line flag; contents need no reset
  // because occupancy gates every read of the array.
  always_ff @(posedge clk_logic) begin
    if (push) mem_q[wr_ptr_q] <= {(k_q == K_LAST), video_data_i};
  end

endmodule

// File: tb/tb_apple_video_fetch.sv
// Self-checking bench for apple_video_fetch: randomized lines and handshakes
// checked against an address/data model computed directly from the Apple II
// scanner rules.
module tb_apple_video_fetch;

  localparam int DEPTH = 4;
  localparam int LAT   = 1;

  logic        clk = 1'b0;
  logic        system_reset_n;
  logic        line_start_i;
  logic [8:0]  line_i;
  logic        text_mode_i, mixed_mode_i, page2_i, hires_mode_i, store80_i;
  logic [15:0] video_address_o;
  logic        video_rd_o;
  logic [31:0] video_data_i;
  logic [31:0] word_o;
  logic        word_valid_o;
  logic        word_ready_i;
  logic        word_last_o;
  logic        line_done_o;
  logic        busy_o;

  always #5 clk = ~clk;

  apple_video_fetch #(.FIFO_DEPTH(DEPTH), .READ_LATENCY(LAT)) dut (
    .clk_logic      (clk),
    .system_reset_n (system_reset_n),
    .line_start_i   (line_start_i),
    .line_i         (line_i),
    .text_mode_i    (text_mode_i),
    .mixed_mode_i   (mixed_mode_i),
    .page2_i        (page2_i),
    .hires_mode_i   (hires_mode_i),
    .store80_i      (store80_i),
    .video_address_o(video_address_o),
    .video_rd_o     (video_rd_o),
    .video_data_i   (video_data_i),
    .word_o         (word_o),
    .word_valid_o   (word_valid_o),
    .word_ready_i   (word_ready_i),
    .word_last_o    (word_last_o),
    .line_done_o    (line_done_o),
    .busy_o         (busy_o)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] salt;
  logic [15:0] rd_log[$];
  logic [31:0] w_log[$];
  logic        l_log[$];
  int          done_cnt;

  // Shadow memory contents as a function of bus address.
  function automatic logic [31:0] memf(input logic [15:0] a);
    return ({16'h0, a} * 32'h9E37_79B1) ^ salt;
  endfunction

  // Reference scanner base address computed with plain integer arithmetic.
  function automatic int exp_base(input int ln, input bit t, input bit m,
                                  input bit p2, input bit h, input bit s80);
    int pg, r;
    pg = (p2 && !s80) ? 1 : 0;
    if (t || (m && ln >= 160) || !h) begin
      r = ln / 8;
      return 1024 + pg * 1024 + (r % 8) * 128 + (r / 8) * 40;
    end
    return 8192 + pg * 8192 + (ln % 8) * 1024 + ((ln / 8) % 8) * 128 + (ln / 64) * 40;
  endfunction

  // Shadow memory responder: data valid one cycle after an accepted read,
  // noise otherwise.
  always @(posedge clk) begin
    video_data_i <= video_rd_o ? memf(video_address_o) : $urandom;
  end

  // Transaction monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (system_reset_n) begin
      if (video_rd_o) rd_log.push_back(video_address_o);
      if (word_valid_o && word_ready_i) begin
        w_log.push_back(word_o);
        l_log.push_back(word_last_o);
        $display("  word %0d: data=%08h last=%0b", w_log.size() - 1, word_o, word_last_o);
      end
      if (line_done_o) done_cnt++;
    end
  end

  task automatic clear_logs();
    rd_log.delete();
    w_log.delete();
    l_log.delete();
    done_cnt = 0;
  endtask

  task automatic start_line(input int ln, input bit t, input bit m,
                            input bit p2, input bit h, input bit s80);
    line_i       = ln[8:0];
    text_mode_i  = t;
    mixed_mode_i = m;
    page2_i      = p2;
    hires_mode_i = h;
    store80_i    = s80;
    line_start_i = 1'b1;
    $display("line start: line=%0d text=%0b mixed=%0b page2=%0b hires=%0b store80=%0b",
             ln, t, m, p2, h, s80);
    @(posedge clk); #1;
    line_start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      word_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      if (done_cnt > 0) begin
        to = 1'b0;
        break;
      end
    end
    word_ready_i = 1'b1;
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    system_reset_n = 1'b0;
    #23;
    checks++; if (video_address_o !== 16'h0) begin errors++; $display("FAIL reset_addr: got %h want 0000", video_address_o); end
    checks++; if (video_rd_o !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b want 0", video_rd_o); end
    checks++; if (word_o !== 32'h0) begin errors++; $display("FAIL reset_word: got %h want 0", word_o); end
    checks++; if (word_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", word_valid_o); end
    checks++; if (word_last_o !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", word_last_o); end
    checks++; if (line_done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", line_done_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    @(posedge clk); #1;
    system_reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("reset: checked");
  endtask

  // Full line in text mode, page 1, line 0 with the consumer always ready.
  task automatic test_text();
    bit to;
    int b;
    clear_logs();
    salt = $urandom;
    start_line(0, 1, 0, 0, 0, 0);
    wait_done(400, 0, to);
    b = exp_base(0, 1, 0, 0, 0, 0);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL text_timeout: line_done never seen"); end
    checks++; if (rd_log.size() !== 20) begin errors++; $display("FAIL text_reads: got %0d want 20", rd_log.size()); end
    for (int k = 0; k < 20; k++) begin
      logic [15:0] ga; logic [31:0] gw; logic gl;
      ga = (k < rd_log.size()) ? rd_log[k] : 16'hxxxx;
      gw = (k < w_log.size()) ? w_log[k] : 32'hxxxx_xxxx;
      gl = (k < l_log.size()) ? l_log[k] : 1'bx;
      checks++; if (ga !== 16'(b + 2 * k)) begin errors++; $display("FAIL text_addr[%0d]: got %h want %h", k, ga, 16'(b + 2 * k)); end
      checks++; if (gw !== memf(16'(b + 2 * k))) begin errors++; $display("FAIL text_word[%0d]: got %h want %h", k, gw, memf(16'(b + 2 * k))); end
      checks++; if (gl !== (k == 19)) begin errors++; $display("FAIL text_last[%0d]: got %b want %b", k, gl, (k == 19)); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL text_done: got %0d pulses want 1", done_cnt); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL text_busy_after: got %b want 0", busy_o); end
  endtask

  // Hires first addresses across page and store80 combinations.
  task automatic test_hires();
    bit to;
    int lns[3]    = '{1, 65, 1};
    bit p2s[3]    = '{1, 0, 1};
    bit s80s[3]   = '{0, 0, 1};
    logic [15:0] want[3] = '{16'h4400, 16'h2428, 16'h2400};
    for (int i = 0; i < 3; i++) begin
      clear_logs();
      salt = $urandom;
      start_line(lns[i], 0, 0, p2s[i], 1, s80s[i]);
      wait_done(400, 0, to);
      checks++; if (to !== 1'b0 || rd_log.size() !== 20) begin errors++; $display("FAIL hires_reads[%0d]: got %0d reads timeout=%b want 20", i, rd_log.size(), to); end
      checks++; if (rd_log.size() == 0 || rd_log[0] !== want[i]) begin errors++; $display("FAIL hires_first[%0d]: got %h want %h", i, (rd_log.size() > 0) ? rd_log[0] : 16'hxxxx, want[i]); end
    end
  endtask

  // Mixed mode bottom area switches a hires frame to text addressing.
  task automatic test_mixed();
    bit to;
    clear_logs();
    salt = $urandom;
    start_line(168, 0, 1, 0, 1, 0);
    wait_done(400, 0, to);
    checks++; if (rd_log.size() !== 20 || to !== 1'b0) begin errors++; $display("FAIL mixed_reads: got %0d want 20", rd_log.size()); end
    checks++; if (rd_log.size() == 0 || rd_log[0] !== 16'h06D0) begin errors++; $display("FAIL mixed_first: got %h want 06d0", (rd_log.size() > 0) ? rd_log[0] : 16'hxxxx); end
    checks++; if (rd_log.size() == 0 || rd_log[rd_log.size() - 1] !== 16'h06F6) begin errors++; $display("FAIL mixed_last: got %h want 06f6", (rd_log.size() > 0) ? rd_log[rd_log.size() - 1] : 16'hxxxx); end
  endtask

  // Random lines, random soft switches, random consumer backpressure.
  task automatic test_random_lines();
    bit to;
    int ln, b;
    bit t, m, p2, h, s80;
    for (int n = 0; n < 8; n++) begin
      clear_logs();
      salt = $urandom;
      ln = $urandom_range(0, 191);
      t = 1'($urandom); m = 1'($urandom); p2 = 1'($urandom); h = 1'($urandom); s80 = 1'($urandom);
      start_line(ln, t, m, p2, h, s80);
      wait_done(600, 1, to);
      b = exp_base(ln, t, m, p2, h, s80);
      checks++; if (to !== 1'b0 || rd_log.size() !== 20 || w_log.size() !== 20) begin errors++; $display("FAIL rand_counts[%0d]: reads=%0d words=%0d timeout=%b want 20/20/0", n, rd_log.size(), w_log.size(), to); end
      for (int k = 0; k < 20; k++) begin
        logic [15:0] ga; logic [31:0] gw; logic gl;
        ga = (k < rd_log.size()) ? rd_log[k] : 16'hxxxx;
        gw = (k < w_log.size()) ? w_log[k] : 32'hxxxx_xxxx;
        gl = (k < l_log.size()) ? l_log[k] : 1'bx;
        checks++; if (ga !== 16'(b + 2 * k)) begin errors++; $display("FAIL rand_addr[%0d][%0d]: got %h want %h", n, k, ga, 16'(b + 2 * k)); end
        checks++; if (gw !== memf(16'(b + 2 * k)) || gl !== (k == 19)) begin errors++; $display("FAIL rand_word[%0d][%0d]: got %h/%b want %h/%b", n, k, gw, gl, memf(16'(b + 2 * k)), (k == 19)); end
      end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rand_done[%0d]: got %0d want 1", n, done_cnt); end
    end
  endtask

  // Consumer stalled from the start: reads stop once the FIFO is full.
  task automatic test_backpressure();
    bit to;
    logic [31:0] hold;
    clear_logs();
    salt = $urandom;
    word_ready_i = 1'b0;
    start_line(0, 1, 0, 0, 0, 0);
    repeat (30) @(posedge clk);
    #1;
    checks++; if (rd_log.size() !== DEPTH) begin errors++; $display("FAIL bp_reads: got %0d want %0d", rd_log.size(), DEPTH); end
    checks++; if (video_rd_o !== 1'b0) begin errors++; $display("FAIL bp_rd: got %b want 0", video_rd_o); end
    checks++; if (word_valid_o !== 1'b1 || word_o !== memf(16'h0400)) begin errors++; $display("FAIL bp_head: got %b/%h want 1/%h", word_valid_o, word_o, memf(16'h0400)); end
    hold = word_o;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (word_o !== hold || word_last_o !== 1'b0) begin errors++; $display("FAIL bp_stable: got %h/%b want %h/0", word_o, word_last_o, hold); end
    wait_done(400, 0, to);
    checks++; if (to !== 1'b0 || w_log.size() !== 20 || rd_log.size() !== 20) begin errors++; $display("FAIL bp_counts: words=%0d reads=%0d timeout=%b want 20/20/0", w_log.size(), rd_log.size(), to); end
    for (int k = 0; k < 20; k++) begin
      logic [31:0] gw;
      gw = (k < w_log.size()) ? w_log[k] : 32'hxxxx_xxxx;
      checks++; if (gw !== memf(16'(16'h0400 + 2 * k))) begin errors++; $display("FAIL bp_word[%0d]: got %h want %h", k, gw, memf(16'(16'h0400 + 2 * k))); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
  endtask

  // New line_start after 5 words aborts line 0 and restarts at line 8.
  task automatic test_abort();
    bit to, seen;
    clear_logs();
    salt = $urandom;
    word_ready_i = 1'b1;
    start_line(0, 1, 0, 0, 0, 0);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (w_log.size() >= 5) begin seen = 1'b1; break; end
    end
    word_ready_i = 1'b0;
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL abort_five_words: got %0d words want 5", w_log.size()); end
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL abort_early_done: got %0d want 0", done_cnt); end
    clear_logs();
    start_line(8, 1, 0, 0, 0, 0);
    wait_done(400, 0, to);
    checks++; if (to !== 1'b0 || rd_log.size() !== 20 || w_log.size() !== 20) begin errors++; $display("FAIL abort_counts: reads=%0d words=%0d timeout=%b want 20/20/0", rd_log.size(), w_log.size(), to); end
    checks++; if (rd_log.size() == 0 || rd_log[0] !== 16'h0480) begin errors++; $display("FAIL abort_first: got %h want 0480", (rd_log.size() > 0) ? rd_log[0] : 16'hxxxx); end
    for (int k = 0; k < 20; k++) begin
      logic [31:0] gw;
      gw = (k < w_log.size()) ? w_log[k] : 32'hxxxx_xxxx;
      checks++; if (gw !== memf(16'(16'h0480 + 2 * k))) begin errors++; $display("FAIL abort_word[%0d]: got %h want %h", k, gw, memf(16'(16'h0480 + 2 * k))); end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL abort_done: got %0d want 1", done_cnt); end
  endtask

  // Line 192 is outside the display: no reads, done pulse one cycle later.
  task automatic test_empty_line();
    clear_logs();
    start_line(192, 1, 0, 0, 0, 0);
    checks++; if (line_done_o !== 1'b1) begin errors++; $display("FAIL empty_done_pulse: got %b want 1", line_done_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL empty_busy: got %b want 0", busy_o); end
    @(posedge clk); #1;
    checks++; if (line_done_o !== 1'b0) begin errors++; $display("FAIL empty_done_width: got %b want 0", line_done_o); end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (rd_log.size() !== 0) begin errors++; $display("FAIL empty_reads: got %0d want 0", rd_log.size()); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL empty_done_count: got %0d want 1", done_cnt); end
  endtask

  // Asynchronous reset during a stalled line clears every output at once.
  task automatic test_reset_midline();
    clear_logs();
    salt = $urandom;
    word_ready_i = 1'b0;
    start_line(100, 0, 0, 0, 1, 0);
    repeat (8) @(posedge clk);
    #3;
    system_reset_n = 1'b0;
    #1;
    checks++; if (video_address_o !== 16'h0 || video_rd_o !== 1'b0) begin errors++; $display("FAIL mreset_bus: got %h/%b want 0000/0", video_address_o, video_rd_o); end
    checks++; if (word_o !== 32'h0 || word_valid_o !== 1'b0 || word_last_o !== 1'b0) begin errors++; $display("FAIL mreset_word: got %h/%b/%b want 0/0/0", word_o, word_valid_o, word_last_o); end
    checks++; if (line_done_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL mreset_status: got done=%b busy=%b want 0/0", line_done_o, busy_o); end
    @(posedge clk); #1;
    system_reset_n = 1'b1;
    word_ready_i = 1'b1;
    clear_logs();
    repeat (30) @(posedge clk);
    #1;
    checks++; if (rd_log.size() !== 0 || w_log.size() !== 0) begin errors++; $display("FAIL mreset_idle: reads=%0d words=%0d want 0/0", rd_log.size(), w_log.size()); end
    checks++; if (busy_o !== 1'b0 || done_cnt !== 0) begin errors++; $display("FAIL mreset_quiet: busy=%b done=%0d want 0/0", busy_o, done_cnt); end
  endtask

  initial begin
    line_start_i = 1'b0;
    line_i = 9'd0;
    text_mode_i = 1'b0; mixed_mode_i = 1'b0; page2_i = 1'b0;
    hires_mode_i = 1'b0; store80_i = 1'b0;
    word_ready_i = 1'b1;
    salt = 32'h0;
    done_cnt = 0;
    test_reset();
    test_text();
    test_hires();
    test_mixed();
    test_random_lines();
    test_backpressure();
    test_abort();
    test_empty_line();
    test_reset_midline();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
